// File: rtl/itrx_ahbl_pkg.sv
// Shared AHB-Lite type definitions used by bus-facing blocks.
package itrx_ahbl_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } te_htrans;

  typedef enum logic {
    HWRITE_READ  = 1'b0,
    HWRITE_WRITE = 1'b1
  } te_hwrite;

  typedef enum logic [2:0] {
    HSIZE_BYTE     = 3'd0,
    HSIZE_HALFWORD = 3'd1,
    HSIZE_WORD     = 3'd2,
    HSIZE_DWORD    = 3'd3,
    HSIZE_4WORD    = 3'd4,
    HSIZE_8WORD    = 3'd5,
    HSIZE_16WORD   = 3'd6,
    HSIZE_32WORD   = 3'd7
  } te_hsize;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } te_hresp;

endpackage

// File: rtl/itrx_ahbl_reg_bridge_pkg.sv
// Types and constants for the AHB-Lite to register-bus bridge.
package itrx_ahbl_reg_bridge_pkg;
  import itrx_ahbl_pkg::*;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } te_brg_state;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic te_hresp state_hresp(te_brg_state st);
    return (st == ST_ERR1 || st == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  endfunction

endpackage

// File: rtl/itrx_ahbl_be_gen.sv
// Byte-enable generation and size/alignment check for one AHB transfer.
module itrx_ahbl_be_gen
  import itrx_ahbl_pkg::*;
  import itrx_ahbl_reg_bridge_pkg::*;
(
  input  logic [2:0] hsize_i,
  input  logic [1:0] haddr_i,
  output logic [3:0] be_o,
  output logic       size_err_o
);

  always_comb begin
    be_o       = '0;
    size_err_o = 1'b0;
    case (te_hsize'(hsize_i))
      HSIZE_BYTE: be_o = BE_BYTE << haddr_i;
      HSIZE_HALFWORD: begin
        be_o       = BE_HALF << haddr_i;
        size_err_o = haddr_i[0];
      end
      HSIZE_WORD: begin
        be_o       = BE_WORD;
        size_err_o = |haddr_i;
      end
      default: size_err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/itrx_ahbl_reg_bridge.sv
// AHB-Lite slave turning single transfers into req/ack register accesses,
// with wait states, alignment checking, register error and access timeout.
module itrx_ahbl_reg_bridge
  import itrx_ahbl_pkg::*;
  import itrx_ahbl_reg_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [3:0]        hprot,
  input  logic              hready,
  input  logic [31:0]       hwdata,
  output logic [31:0]       hrdata,
  output logic              hreadyout,
  output logic              hresp,
  output logic              reg_req,
  output logic              reg_wr,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [3:0]        reg_be,
  output logic              reg_priv,
  output logic [31:0]       reg_wdata,
  input  logic [31:0]       reg_rdata,
  input  logic              reg_ack,
  input  logic              reg_err
);

  localparam int unsigned     CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit              TmoEn   = (TIMEOUT != 0);
  localparam logic [CntW-1:0] CntLast = TmoEn ? CntW'(TIMEOUT - 1) : '0;

  te_brg_state       state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              wr_q, priv_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q, be;
  logic [31:0]       hrdata_q;
  logic              size_err, accept, can_accept, take;

  // Only hprot[1] (privileged) is forwarded.
  logic unused_hprot;
  assign unused_hprot = ^{hprot[3:2], hprot[0]};

  itrx_ahbl_be_gen u_be_gen (
    .hsize_i    (hsize),
    .haddr_i    (haddr[1:0]),
    .be_o       (be),
    .size_err_o (size_err)
  );

  assign accept     = hsel & hready & (te_htrans'(htrans) inside {HTRANS_NONSEQ, HTRANS_SEQ});
  assign can_accept = (state_q inside {ST_IDLE, ST_DONE, ST_ERR2});
  assign take       = can_accept & accept;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        cnt_d = '0;
        if (accept) begin
          state_d = size_err ? ST_ERR1 : ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        cnt_d = cnt_q + CntW'(1);
        if (reg_ack) begin
          state_d = reg_err ? ST_ERR1 : ST_DONE;
        end else if (TmoEn && cnt_q == CntLast) begin
          state_d = ST_ERR1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      priv_q   <= 1'b0;
      hrdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take) begin
        wr_q   <= hwrite;
        addr_q <= {haddr[ADDR_W-1:2], 2'b00};
        be_q   <= be;
        priv_q <= hprot[1];
      end
      // Read data is latched only on a clean read completion; writes leave it untouched.
      if (state_q == ST_ACCESS && reg_ack && !reg_err && !wr_q) begin
        hrdata_q <= reg_rdata;
      end
    end
  end

  assign hreadyout = can_accept;
  assign hresp     = state_hresp(state_q);
  assign hrdata    = hrdata_q;
  assign reg_req   = (state_q == ST_ACCESS);
  assign reg_wr    = wr_q;
  assign reg_addr  = addr_q;
  assign reg_be    = be_q;
  assign reg_priv  = priv_q;
  assign reg_wdata = hwdata;

endmodule

// File: tb/tb_itrx_ahbl_reg_bridge.sv
// Scoreboard bench for itrx_ahbl_reg_bridge: directed cases then random AHB traffic.
module tb_itrx_ahbl_reg_bridge;

  localparam int unsigned AW  = 12;
  localparam int unsigned TMO = 4;

  logic          hclk = 1'b0;
  logic          hresetn, hsel, hwrite, hready, hreadyout, hresp;
  logic [AW-1:0] haddr, reg_addr;
  logic [1:0]    htrans;
  logic [2:0]    hsize;
  logic [3:0]    hprot, reg_be;
  logic [31:0]   hwdata, hrdata, reg_wdata;
  logic          reg_req, reg_wr, reg_priv;
  logic [31:0]   reg_rdata = '0;
  logic          reg_ack   = 1'b0;
  logic          reg_err   = 1'b0;

  always #5 hclk = ~hclk;
  assign hready = hreadyout;

  itrx_ahbl_reg_bridge #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .hsel      (hsel),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hprot     (hprot),
    .hready    (hready),
    .hwdata    (hwdata),
    .hrdata    (hrdata),
    .hreadyout (hreadyout),
    .hresp     (hresp),
    .reg_req   (reg_req),
    .reg_wr    (reg_wr),
    .reg_addr  (reg_addr),
    .reg_be    (reg_be),
    .reg_priv  (reg_priv),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .reg_ack   (reg_ack),
    .reg_err   (reg_err)
  );

  typedef struct {
    bit        wr;
    bit [11:0] addr;
    bit [2:0]  size;
    bit [3:0]  prot;
    bit [31:0] wdata;
    int        n;      // req cycles without ack before the ack cycle
    bit        err;
    bit        never;  // never ack: forces a timeout
    bit [31:0] rdata;
  } txn_t;

  typedef struct {
    bit        wr;
    bit [11:0] addr;
    bit [3:0]  be;
    bit        priv;
    bit [31:0] wdata;
    int        n;
    bit        err;
    bit        never;
    bit [31:0] rdata;
  } reqexp_t;

  typedef struct {
    bit        err;
    int        low;
    int        reqs;
    bit [31:0] hrdata;
  } rspexp_t;

  reqexp_t   req_q[$];
  rspexp_t   rsp_q[$];
  int        n_cmp = 0;
  int        n_fail = 0;
  bit [31:0] model_hrdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expectations derived from transfer size/alignment and the responder plan.
  task automatic issue(input txn_t t);
    reqexp_t rq;
    rspexp_t rs;
    int      bytes;
    bit      legal;
    bit      ok;
    bytes = 1 << t.size;
    legal = (t.size <= 3'd2) && ((t.addr % bytes) == 0);
    if (legal) begin
      rq.wr    = t.wr;
      rq.addr  = t.addr & 12'hFFC;
      rq.be    = 4'(((1 << bytes) - 1) << (t.addr % 4));
      rq.priv  = t.prot[1];
      rq.wdata = t.wdata;
      rq.n     = t.n;
      rq.err   = t.err;
      rq.never = t.never;
      rq.rdata = t.rdata;
      req_q.push_back(rq);
      rs.reqs = t.never ? TMO : t.n + 1;
      rs.low  = t.never ? TMO + 1 : (t.err ? t.n + 2 : t.n + 1);
      rs.err  = t.never || t.err;
      if (!rs.err && !t.wr) model_hrdata = t.rdata;
    end else begin
      rs.reqs = 0;
      rs.low  = 1;
      rs.err  = 1'b1;
    end
    rs.hrdata = model_hrdata;
    rsp_q.push_back(rs);

    hsel   = 1'b1;
    htrans = 2'b10;
    haddr  = t.addr;
    hwrite = t.wr;
    hsize  = t.size;
    hprot  = t.prot;
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge hclk);
      if (hreadyout) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("addr_accept_timeout", 32'd1, 32'd0);
    @(posedge hclk);
    #1;
    hwdata = t.wdata;
    hsel   = 1'b0;
    htrans = 2'b00;
    haddr  = AW'($urandom);
  endtask

  task automatic idle_cycles(input int k);
    repeat (k) begin
      hsel   = 1'($urandom);
      htrans = hsel ? 2'($urandom % 2) : 2'($urandom);
      haddr  = AW'($urandom);
      @(posedge hclk);
      #1;
    end
    hsel   = 1'b0;
    htrans = 2'b00;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge hclk);
      if (rsp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 32'd1, 32'd0);
    @(posedge hclk);
    #1;
  endtask

  function automatic txn_t mk(input bit wr, input bit [11:0] addr, input bit [2:0] size,
                              input bit [31:0] wdata, input int n, input bit err,
                              input bit never, input bit [31:0] rdata);
    txn_t t;
    t.wr = wr; t.addr = addr; t.size = size; t.prot = 4'($urandom); t.wdata = wdata;
    t.n = n; t.err = err; t.never = never; t.rdata = rdata;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    int   r;
    r = $urandom % 10;
    t.size = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'(3 + $urandom % 5);
    t.addr = 12'($urandom);
    if (t.size <= 3'd2 && ($urandom % 10) < 7) t.addr = t.addr & ~12'((1 << t.size) - 1);
    t.wr    = 1'($urandom);
    t.prot  = 4'($urandom);
    t.wdata = $urandom;
    t.rdata = $urandom;
    t.n     = $urandom % 4;
    t.err   = ($urandom % 8) == 0;
    t.never = ($urandom % 10) == 0;
    return t;
  endfunction

  // Register-side responder: checks each request and acks per the popped plan.
  int      rcnt = 0;
  reqexp_t cur = '{default: 0};
  always @(negedge hclk) begin
    if (reg_req) begin
      if (rcnt == 0) begin
        if (req_q.size() == 0) begin
          check("unexpected_reg_req", 32'd1, 32'd0);
          cur = '{default: 0};
          cur.never = 1'b1;
        end else begin
          cur = req_q.pop_front();
          check("reg_wr", 32'(reg_wr), 32'(cur.wr));
          check("reg_addr", 32'(reg_addr), 32'(cur.addr));
          check("reg_be", 32'(reg_be), 32'(cur.be));
          check("reg_priv", 32'(reg_priv), 32'(cur.priv));
          check("reg_wdata", reg_wdata, cur.wdata);
        end
      end
      if (!cur.never && rcnt == cur.n) begin
        reg_ack   = 1'b1;
        reg_err   = cur.err;
        reg_rdata = cur.rdata;
      end else begin
        reg_ack   = 1'b0;
        reg_err   = 1'($urandom);
        reg_rdata = $urandom;
      end
      rcnt++;
    end else begin
      // A late ack after a timed-out access must be ignored.
      reg_ack   = (rcnt > 0) && cur.never;
      reg_err   = 1'b0;
      reg_rdata = $urandom;
      rcnt      = 0;
    end
  end

  // AHB response monitor.
  bit in_data = 1'b0;
  int low = 0;
  int req_cnt = 0;
  int req_base = 0;
  bit prev_hresp = 1'b0;
  always @(negedge hclk) begin
    rspexp_t e;
    if (reg_req) req_cnt++;
    if (!hresetn) begin
      in_data  = 1'b0;
      low      = 0;
      req_base = req_cnt;
    end else begin
      if (in_data) begin
        if (hreadyout) begin
          if (rsp_q.size() == 0) begin
            check("unexpected_response", 32'd1, 32'd0);
          end else begin
            e = rsp_q.pop_front();
            check("hresp", 32'(hresp), 32'(e.err));
            check("hresp_last_wait", 32'(prev_hresp), 32'(e.err));
            check("wait_cycles", 32'(low), 32'(e.low));
            check("req_cycles", 32'(req_cnt - req_base), 32'(e.reqs));
            check("hrdata", hrdata, e.hrdata);
          end
          in_data  = 1'b0;
          req_base = req_cnt;
        end else begin
          low++;
          prev_hresp = hresp;
        end
      end
      if (hsel && hreadyout && htrans[1]) begin
        in_data = 1'b1;
        low     = 0;
      end
    end
  end

  initial begin
    hresetn = 1'b0;
    hsel    = 1'b0;
    htrans  = 2'b00;
    haddr   = '0;
    hwrite  = 1'b0;
    hsize   = 3'd0;
    hprot   = 4'd0;
    hwdata  = '0;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    check("rst_hreadyout", 32'(hreadyout), 32'd1);
    check("rst_hresp", 32'(hresp), 32'd0);
    check("rst_hrdata", hrdata, 32'd0);
    check("rst_reg_req", 32'(reg_req), 32'd0);
    check("rst_reg_wr", 32'(reg_wr), 32'd0);
    check("rst_reg_addr", 32'(reg_addr), 32'd0);
    check("rst_reg_be", 32'(reg_be), 32'd0);
    check("rst_reg_priv", 32'(reg_priv), 32'd0);
    @(posedge hclk);
    #1;
    hresetn = 1'b1;
    @(posedge hclk);
    #1;

    issue(mk(1'b1, 12'h010, 3'd2, 32'hDEADBEEF, 0, 1'b0, 1'b0, 32'h0));
    wait_done();
    issue(mk(1'b0, 12'h013, 3'd0, 32'h0, 2, 1'b0, 1'b0, 32'h12345678));
    wait_done();
    issue(mk(1'b0, 12'h002, 3'd2, 32'h0, 0, 1'b0, 1'b0, 32'hFFFF0000));
    wait_done();
    issue(mk(1'b1, 12'h000, 3'd3, 32'h0BAD0BAD, 0, 1'b0, 1'b0, 32'h0));
    wait_done();
    issue(mk(1'b0, 12'h020, 3'd2, 32'h0, 0, 1'b0, 1'b1, 32'hCAFEF00D));
    wait_done();
    issue(mk(1'b1, 12'h024, 3'd2, 32'h11112222, 0, 1'b0, 1'b0, 32'h0));
    issue(mk(1'b0, 12'h028, 3'd2, 32'h0, 1, 1'b1, 1'b0, 32'h55555555));
    wait_done();

    // Reset while an access is outstanding abandons it.
    issue(mk(1'b0, 12'h02C, 3'd2, 32'h0, 0, 1'b0, 1'b1, 32'h0));
    @(posedge hclk);
    #1;
    hresetn = 1'b0;
    rsp_q.delete();
    req_q.delete();
    model_hrdata = '0;
    @(posedge hclk);
    #1;
    hresetn = 1'b1;
    @(negedge hclk);
    check("arst_reg_req", 32'(reg_req), 32'd0);
    check("arst_hreadyout", 32'(hreadyout), 32'd1);
    check("arst_hresp", 32'(hresp), 32'd0);
    check("arst_hrdata", hrdata, 32'd0);
    @(posedge hclk);
    #1;
    issue(mk(1'b0, 12'h032, 3'd1, 32'h0, 0, 1'b0, 1'b0, 32'hA5A55A5A));
    wait_done();

    for (int i = 0; i < 60; i++) begin
      issue(rand_txn());
      if ($urandom % 2) idle_cycles($urandom % 3);
    end
    wait_done();
    check("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
    check("req_queue_empty", 32'(req_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
